// File: rtl/fp_result_out_buffer_if.sv
// Result handshake bundle between the FPU output buffer and its environment.
// The buffer uses the master modport; the FPU/consumer side uses the slave modport.
interface fp_result_out_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  // Handshake: result_ready_o high means out_bus_o holds an unconsumed result; the consumer
  // takes it by raising result_accepted_i. In four-phase mode accepted must drop before the
  // next result is offered; in valid/ready mode ready & accepted at an edge is one transfer.
  logic             done_i;
  logic [WIDTH-1:0] result_i;
  logic             result_accepted_i;
  logic [WIDTH-1:0] out_bus_o;
  logic             result_ready_o;
  logic [CW-1:0]    count_o;
  logic             full_o;
  logic             empty_o;
  logic             overflow_o;

  modport master (
    input  done_i, result_i, result_accepted_i,
    output out_bus_o, result_ready_o, count_o, full_o, empty_o, overflow_o
  );

  modport slave (
    output done_i, result_i, result_accepted_i,
    input  out_bus_o, result_ready_o, count_o, full_o, empty_o, overflow_o
  );
endinterface

// File: rtl/fp_result_out_buffer.sv
// FPU result output stage: done-edge capture into a FIFO, registered presenter with a
// four-phase or valid/ready handshake. Optional macro OUT_BUF_DROP_CNT_EN adds drop_cnt_o.
module fp_result_out_buffer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int HS_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_result_out_buffer_if.master bus,
  output logic [1:0]            state_dbg
`ifdef OUT_BUF_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             done_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] out_bus;
  logic             overflow;
  logic             push_req, push, pop, drop, full, empty;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_req = bus.done_i & ~done_q;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.result_accepted_i) begin
          if (HS_MODE == 1) begin
            if (!empty) pop = 1'b1;
            else        state_nxt = IDLE;
          end else begin
            state_nxt = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (!bus.result_accepted_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_bus  <= '0;
      overflow <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= bus.done_i;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        out_bus <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.result_i;
  end

`ifdef OUT_BUF_DROP_CNT_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt;
`endif

  assign bus.out_bus_o      = out_bus;
  assign bus.result_ready_o = (state == PRESENT);
  assign bus.count_o        = count;
  assign bus.full_o         = full;
  assign bus.empty_o        = empty;
  assign bus.overflow_o     = overflow;
  assign state_dbg          = state;
endmodule

// File: tb/tb_fp_result_out_buffer.sv
// Bench for fp_result_out_buffer: one four-phase and one valid/ready instance, scoreboard
// queues per instance filled when results are driven and drained when results are presented.
module tb_fp_result_out_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_result_out_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
  fp_result_out_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();
  logic [1:0] state0, state1;
`ifdef OUT_BUF_DROP_CNT_EN
  logic [7:0] drop0, drop1;
`endif

  fp_result_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HS_MODE(0)) u_hs0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(state0)
`ifdef OUT_BUF_DROP_CNT_EN
    , .drop_cnt_o(drop0)
`endif
  );

  fp_result_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HS_MODE(1)) u_hs1 (
    .clk(clk), .rst(rst), .bus(bus1), .state_dbg(state1)
`ifdef OUT_BUF_DROP_CNT_EN
    , .drop_cnt_o(drop1)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp0_q[$];
  logic [WIDTH-1:0] exp1_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic pulse0(input logic [WIDTH-1:0] v, input bit kept);
    bus0.result_i = v;
    bus0.done_i   = 1'b1;
    if (kept) exp0_q.push_back(v);
    @(negedge clk);
    bus0.done_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse1(input logic [WIDTH-1:0] v, input bit kept);
    bus1.result_i = v;
    bus1.done_i   = 1'b1;
    if (kept) exp1_q.push_back(v);
    @(negedge clk);
    bus1.done_i = 1'b0;
    @(negedge clk);
  endtask

  // Four-phase consume of one result on instance 0, checking the scoreboard head.
  task automatic hs0_consume(input string name);
    int n;
    logic [WIDTH-1:0] e;
    n = 0;
    while (!bus0.result_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus0.result_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready: got=%0b want=1", name, bus0.result_ready_o);
      return;
    end
    total++;
    if (exp0_q.size() == 0) begin
      bad++;
      $display("FAIL %s_unexpected: got=%0d want=no result", name, bus0.out_bus_o);
    end else begin
      e = exp0_q.pop_front();
      if (bus0.out_bus_o !== e) begin
        bad++;
        $display("FAIL %s_data: got=%0d want=%0d", name, bus0.out_bus_o, e);
      end
    end
    bus0.result_accepted_i = 1'b1;
    @(negedge clk);
    total++;
    if (bus0.result_ready_o !== 1'b0 || state0 !== 2'd2) begin
      bad++;
      $display("FAIL %s_release: got ready=%0b state=%0d want ready=0 state=2",
               name, bus0.result_ready_o, state0);
    end
    @(negedge clk);
    bus0.result_accepted_i = 1'b0;
    @(negedge clk);
    total++;
    if (state0 !== 2'd0) begin
      bad++;
      $display("FAIL %s_idle: got state=%0d want=0", name, state0);
    end
  endtask

  // Valid/ready drain of n results on instance 1 with accepted held high; one per cycle.
  task automatic hs1_drain(input int n, input string name);
    logic [WIDTH-1:0] e;
    bus1.result_accepted_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      total++;
      if (bus1.result_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL %s_ready[%0d]: got=%0b want=1", name, i, bus1.result_ready_o);
      end
      total++;
      if (exp1_q.size() == 0) begin
        bad++;
        $display("FAIL %s_unexpected[%0d]: got=%0d want=no result", name, i, bus1.out_bus_o);
      end else begin
        e = exp1_q.pop_front();
        if (bus1.out_bus_o !== e) begin
          bad++;
          $display("FAIL %s_data[%0d]: got=%0d want=%0d", name, i, bus1.out_bus_o, e);
        end
      end
      @(negedge clk);
    end
    bus1.result_accepted_i = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (bus0.result_ready_o !== 1'b0 || bus0.out_bus_o !== '0 || bus0.count_o !== '0 ||
        bus0.empty_o !== 1'b1 || bus0.full_o !== 1'b0 || bus0.overflow_o !== 1'b0 || state0 !== 2'd0) begin
      bad++;
      $display("FAIL reset_hs0: got rdy=%0b bus=%0d cnt=%0d emp=%0b full=%0b ovf=%0b st=%0d want 0/0/0/1/0/0/0",
               bus0.result_ready_o, bus0.out_bus_o, bus0.count_o, bus0.empty_o, bus0.full_o,
               bus0.overflow_o, state0);
    end
    total++;
    if (bus1.result_ready_o !== 1'b0 || bus1.out_bus_o !== '0 || bus1.count_o !== '0 ||
        bus1.empty_o !== 1'b1 || bus1.full_o !== 1'b0 || bus1.overflow_o !== 1'b0 || state1 !== 2'd0) begin
      bad++;
      $display("FAIL reset_hs1: got rdy=%0b bus=%0d cnt=%0d emp=%0b full=%0b ovf=%0b st=%0d want 0/0/0/1/0/0/0",
               bus1.result_ready_o, bus1.out_bus_o, bus1.count_o, bus1.empty_o, bus1.full_o,
               bus1.overflow_o, state1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hs0_single();
    bus0.result_i = 20;
    bus0.done_i   = 1'b1;
    exp0_q.push_back(20);
    @(negedge clk);
    total++;
    if (bus0.count_o !== 3'd1 || bus0.result_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL single_capture: got cnt=%0d rdy=%0b want cnt=1 rdy=0", bus0.count_o, bus0.result_ready_o);
    end
    bus0.done_i = 1'b0;
    @(negedge clk);
    total++;
    if (bus0.result_ready_o !== 1'b1 || bus0.count_o !== 3'd0) begin
      bad++;
      $display("FAIL single_latency: got rdy=%0b cnt=%0d want rdy=1 cnt=0", bus0.result_ready_o, bus0.count_o);
    end
    hs0_consume("single");
  endtask

  task automatic test_overflow();
    for (int v = 1; v <= 5; v++) pulse0(WIDTH'(v), 1'b1);
    pulse0(6, 1'b0);
    total++;
    if (bus0.count_o !== 3'd4 || bus0.full_o !== 1'b1 || bus0.overflow_o !== 1'b1 || bus0.out_bus_o !== 32'd1) begin
      bad++;
      $display("FAIL overflow_state: got cnt=%0d full=%0b ovf=%0b bus=%0d want cnt=4 full=1 ovf=1 bus=1",
               bus0.count_o, bus0.full_o, bus0.overflow_o, bus0.out_bus_o);
    end
`ifdef OUT_BUF_DROP_CNT_EN
    total++;
    if (drop0 !== 8'd1) begin
      bad++;
      $display("FAIL overflow_dropcnt: got=%0d want=1", drop0);
    end
`endif
    for (int i = 0; i < 5; i++) hs0_consume("overflow_drain");
    total++;
    if (bus0.empty_o !== 1'b1 || bus0.count_o !== 3'd0 || bus0.overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: got emp=%0b cnt=%0d ovf=%0b want emp=1 cnt=0 ovf=1",
               bus0.empty_o, bus0.count_o, bus0.overflow_o);
    end
  endtask

  task automatic test_held_done();
    int max_cnt;
    max_cnt = 0;
    bus0.result_i = 40;
    bus0.done_i   = 1'b1;
    exp0_q.push_back(40);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (int'(bus0.count_o) > max_cnt) max_cnt = int'(bus0.count_o);
    end
    bus0.done_i = 1'b0;
    total++;
    if (max_cnt !== 1) begin
      bad++;
      $display("FAIL held_max_count: got=%0d want=1", max_cnt);
    end
    hs0_consume("held");
    repeat (4) @(negedge clk);
    total++;
    if (bus0.result_ready_o !== 1'b0 || bus0.count_o !== 3'd0) begin
      bad++;
      $display("FAIL held_single_entry: got rdy=%0b cnt=%0d want rdy=0 cnt=0",
               bus0.result_ready_o, bus0.count_o);
    end
  endtask

  task automatic test_hs1_stream();
    for (int v = 10; v <= 13; v++) pulse1(WIDTH'(v), 1'b1);
    total++;
    if (bus1.count_o !== 3'd3 || bus1.result_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL stream_queued: got cnt=%0d rdy=%0b want cnt=3 rdy=1", bus1.count_o, bus1.result_ready_o);
    end
    hs1_drain(4, "stream");
    total++;
    if (bus1.result_ready_o !== 1'b0 || bus1.empty_o !== 1'b1 || state1 !== 2'd0) begin
      bad++;
      $display("FAIL stream_end: got rdy=%0b emp=%0b st=%0d want rdy=0 emp=1 st=0",
               bus1.result_ready_o, bus1.empty_o, state1);
    end
  endtask

  task automatic test_full_pushpop();
    logic [WIDTH-1:0] e;
    for (int v = 1; v <= 5; v++) pulse1(WIDTH'(v), 1'b1);
    total++;
    if (bus1.full_o !== 1'b1 || bus1.result_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL pushpop_pre: got full=%0b rdy=%0b want full=1 rdy=1", bus1.full_o, bus1.result_ready_o);
    end
    bus1.result_i          = 7;
    bus1.done_i            = 1'b1;
    bus1.result_accepted_i = 1'b1;
    exp1_q.push_back(7);
    e = exp1_q.pop_front();
    total++;
    if (bus1.out_bus_o !== e) begin
      bad++;
      $display("FAIL pushpop_head: got=%0d want=%0d", bus1.out_bus_o, e);
    end
    @(negedge clk);
    bus1.done_i = 1'b0;
    total++;
    if (bus1.count_o !== 3'd4 || bus1.overflow_o !== 1'b0 || bus1.full_o !== 1'b1) begin
      bad++;
      $display("FAIL pushpop_count: got cnt=%0d ovf=%0b full=%0b want cnt=4 ovf=0 full=1",
               bus1.count_o, bus1.overflow_o, bus1.full_o);
    end
    hs1_drain(5, "pushpop");
    total++;
    if (bus1.empty_o !== 1'b1 || bus1.result_ready_o !== 1'b0 || bus1.overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL pushpop_end: got emp=%0b rdy=%0b ovf=%0b want emp=1 rdy=0 ovf=0",
               bus1.empty_o, bus1.result_ready_o, bus1.overflow_o);
    end
  endtask

  task automatic test_reset_mid();
    for (int v = 1; v <= 5; v++) pulse1(WIDTH'(v + 100), 1'b1);
    pulse1(106, 1'b0);
    hs1_drain(2, "midrst");
    total++;
    if (bus1.result_ready_o !== 1'b1 || bus1.count_o !== 3'd2 || bus1.overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre: got rdy=%0b cnt=%0d ovf=%0b want rdy=1 cnt=2 ovf=1",
               bus1.result_ready_o, bus1.count_o, bus1.overflow_o);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (bus1.result_ready_o !== 1'b0 || bus1.out_bus_o !== '0 || bus1.count_o !== '0 ||
        bus1.overflow_o !== 1'b0 || bus1.empty_o !== 1'b1 || bus1.full_o !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: got rdy=%0b bus=%0d cnt=%0d ovf=%0b emp=%0b full=%0b want 0/0/0/0/1/0",
               bus1.result_ready_o, bus1.out_bus_o, bus1.count_o, bus1.overflow_o, bus1.empty_o, bus1.full_o);
    end
    exp1_q.delete();
    exp0_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifdef OUT_BUF_DROP_CNT_EN
    total++;
    if (drop1 !== 8'd0 || drop0 !== 8'd0) begin
      bad++;
      $display("FAIL midrst_dropcnt: got %0d/%0d want 0/0", drop0, drop1);
    end
`endif
    pulse1(99, 1'b1);
    hs1_drain(1, "after_rst");
  endtask

  task automatic test_reset_done_high();
    rst = 1'b1;
    bus0.result_i = 55;
    bus0.done_i   = 1'b1;
    exp0_q.push_back(55);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus0.count_o !== 3'd1) begin
      bad++;
      $display("FAIL done_at_release: got cnt=%0d want=1", bus0.count_o);
    end
    bus0.done_i = 1'b0;
    hs0_consume("done_at_release");
  endtask

  initial begin
    bus0.done_i = 1'b0; bus0.result_i = '0; bus0.result_accepted_i = 1'b0;
    bus1.done_i = 1'b0; bus1.result_i = '0; bus1.result_accepted_i = 1'b0;
    test_reset();
    test_hs0_single();
    test_overflow();
    test_held_done();
    test_hs1_stream();
    test_full_pushpop();
    test_reset_mid();
    test_reset_done_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
